// File: rtl/seq_ctrl_pkg.sv
// Shared types, default sizes and helpers for the programmable sequence matcher.
package seq_ctrl_pkg;

    localparam int PAT_W_DEF = 6;
    localparam int LEN_W_DEF = 3;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A pattern length is usable when it is nonzero and fits the window.
    function automatic logic len_is_legal(input int unsigned len, input int unsigned max_len);
        return (len != 0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/seq_window_matcher.sv
// Shift window and fill tracker; flags a hit when the newest bits complete the pattern.
module seq_window_matcher #(
    parameter int PAT_W = 6,
    parameter int LEN_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             bit_in,
    input  logic [LEN_W-1:0] len,
    input  logic [PAT_W-1:0] pattern,
    output logic             hit
);

    logic [PAT_W-1:0] window_q, window_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0] mask;
    logic [PAT_W-1:0] win_shift;
    logic [LEN_W:0]   fill_inc;

    // Only the low len bits of the window take part in the compare.
    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len));
        end
    end

    // Next window/fill and the hit decision; a hit restarts fill so matches never overlap.
    always_comb begin
        win_shift = {window_q[PAT_W-2:0], bit_in};
        fill_inc  = {1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1};
        if (fill_inc > {1'b0, len}) begin
            fill_inc = {1'b0, len};
        end
        hit = shift_en && (fill_inc == {1'b0, len}) && (((win_shift ^ pattern) & mask) == '0);

        window_d = window_q;
        fill_d   = fill_q;
        if (clear) begin
            window_d = '0;
            fill_d   = '0;
        end else if (shift_en) begin
            window_d = win_shift;
            fill_d   = hit ? '0 : fill_inc[LEN_W-1:0];
        end
    end

    // Window and fill registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window_q <= '0;
            fill_q   <= '0;
        end else begin
            window_q <= window_d;
            fill_q   <= fill_d;
        end
    end

endmodule

// File: rtl/seq_match_ctrl.sv
// Configurable non-overlapping serial pattern detector with start/abort run control.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | waiting for start; config port open
//   ST_RUN  | scanning qualified bits, counting matches; config closed
//   ST_DONE | target count reached; count held, config port open
module seq_match_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_target,
    output logic             cfg_err,
    input  logic             start,
    input  logic             abort,
    input  logic             x_valid,
    input  logic             x,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] tgt_q, tgt_d;
    logic             cfg_loaded_q, cfg_loaded_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic             cfg_err_q, cfg_err_d;

    logic             cfg_fire;
    logic             cfg_legal;
    logic             shift_en;
    logic             win_clear;
    logic             hit;
    logic [CNT_W-1:0] cnt_inc;

    assign cfg_fire  = cfg_valid && (state_q != ST_RUN);
    assign cfg_legal = len_is_legal(32'(cfg_len), 32'(PAT_W));
    // Abort suppresses the bit so an aborting cycle can never produce a match.
    assign shift_en  = (state_q == ST_RUN) && x_valid && !abort;
    assign cnt_inc   = (match_cnt_q == '1) ? match_cnt_q : match_cnt_q + CNT_W'(1);

    seq_window_matcher #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_matcher (
        .clk      (clk),
        .rst      (rst),
        .clear    (win_clear),
        .shift_en (shift_en),
        .bit_in   (x),
        .len      (len_q),
        .pattern  (pat_q),
        .hit      (hit)
    );

    // Config capture, run sequencing and match counting.
    always_comb begin
        state_d      = state_q;
        pat_d        = pat_q;
        len_d        = len_q;
        tgt_d        = tgt_q;
        cfg_loaded_d = cfg_loaded_q;
        match_d      = 1'b0;
        match_cnt_d  = match_cnt_q;
        cfg_err_d    = 1'b0;
        win_clear    = 1'b0;

        if (cfg_fire) begin
            if (cfg_legal) begin
                pat_d        = cfg_pattern;
                len_d        = cfg_len;
                tgt_d        = cfg_target;
                cfg_loaded_d = 1'b1;
            end else begin
                cfg_err_d = 1'b1;
            end
        end

        // Start checks cfg_loaded_d so a config offered with start is usable at once.
        case (state_q)
            ST_IDLE: begin
                if (start && !abort && cfg_loaded_d) begin
                    state_d     = ST_RUN;
                    win_clear   = 1'b1;
                    match_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (hit) begin
                    match_d     = 1'b1;
                    match_cnt_d = cnt_inc;
                    if ((tgt_q != '0) && (cnt_inc == tgt_q)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d     = ST_RUN;
                    win_clear   = 1'b1;
                    match_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, config and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pat_q        <= '0;
            len_q        <= '0;
            tgt_q        <= '0;
            cfg_loaded_q <= 1'b0;
            match_q      <= 1'b0;
            match_cnt_q  <= '0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pat_q        <= pat_d;
            len_q        <= len_d;
            tgt_q        <= tgt_d;
            cfg_loaded_q <= cfg_loaded_d;
            match_q      <= match_d;
            match_cnt_q  <= match_cnt_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign cfg_ready = (state_q != ST_RUN);
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign match     = match_q;
    assign match_cnt = match_cnt_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Scoreboard bench for seq_match_ctrl with a queue-based reference model.
module tb_seq_match_ctrl;

    localparam int PAT_W = 6;
    localparam int LEN_W = 3;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic [CNT_W-1:0] cfg_target;
    logic             cfg_err;
    logic             start;
    logic             abort;
    logic             x_valid;
    logic             x;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             busy;
    logic             done;

    seq_match_ctrl #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_target  (cfg_target),
        .cfg_err     (cfg_err),
        .start       (start),
        .abort       (abort),
        .x_valid     (x_valid),
        .x           (x),
        .match       (match),
        .match_cnt   (match_cnt),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;
    exp_t scb[$];

    // Reference model: run/done flags, accepted-bit history since last match or start.
    bit         m_run, m_done, m_loaded, m_err;
    bit [5:0]   m_pat;
    int         m_len, m_tgt, m_cnt;
    bit         m_hist[$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit hist_matches();
        for (int i = 0; i < m_len; i++) begin
            if (m_hist[i] != m_pat[m_len-1-i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Monitor: every match pulse must line up with the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (scb.size() > 0 && scb[0].cyc == cyc) begin
                e = scb.pop_front();
                check("match_pulse", int'(match), 1);
                check("match_cnt_at_match", int'(match_cnt), e.cnt);
            end else if (match) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_match: match=1, expected 0 (cycle %0d)", cyc);
            end
        end
    end

    task automatic check_levels();
        check("done", int'(done), int'(m_done));
        check("busy", int'(busy), int'(m_run));
        check("cfg_ready", int'(cfg_ready), int'(!m_run));
        check("cfg_err", int'(cfg_err), int'(m_err));
        check("match_cnt", int'(match_cnt), m_cnt);
    endtask

    // One clock: drive at negedge, advance the model, check after the edge.
    task automatic step(input bit cv, input bit [5:0] cp, input int cl, input int ct,
                        input bit st, input bit ab, input bit xv, input bit xb);
        bit fire;
        cfg_valid   = cv;
        cfg_pattern = cp;
        cfg_len     = cl[2:0];
        cfg_target  = ct[7:0];
        start       = st;
        abort       = ab;
        x_valid     = xv;
        x           = xb;

        fire  = cv && !m_run;
        m_err = 1'b0;
        if (fire) begin
            if (cl >= 1 && cl <= PAT_W) begin
                m_pat    = cp;
                m_len    = cl;
                m_tgt    = ct;
                m_loaded = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end
        if (m_run) begin
            if (ab) begin
                m_run = 1'b0;
            end else if (xv) begin
                m_hist.push_back(xb);
                if (m_hist.size() > m_len) void'(m_hist.pop_front());
                if (m_hist.size() == m_len && hist_matches()) begin
                    m_hist.delete();
                    if (m_cnt < 255) m_cnt++;
                    scb.push_back('{cyc: cyc + 1, cnt: m_cnt});
                    if (m_tgt != 0 && m_cnt == m_tgt) begin
                        m_run  = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end
        end else if (ab) begin
            m_done = 1'b0;
        end else if (st && m_loaded) begin
            m_run  = 1'b1;
            m_done = 1'b0;
            m_cnt  = 0;
            m_hist.delete();
        end

        @(posedge clk);
        @(negedge clk);
        check_levels();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        cfg_valid = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        x_valid   = 1'b0;
        x         = 1'b0;
        #1;
        check("rst_match", int'(match), 0);
        check("rst_match_cnt", int'(match_cnt), 0);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cfg_err", int'(cfg_err), 0);
        check("rst_cfg_ready", int'(cfg_ready), 1);
        m_run = 0; m_done = 0; m_loaded = 0; m_err = 0;
        m_pat = '0; m_len = 0; m_tgt = 0; m_cnt = 0;
        m_hist.delete();
        scb.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cfg(input bit [5:0] p, input int l, input int t);
        step(1, p, l, t, 0, 0, 0, 0);
    endtask

    task automatic go();
        step(0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic bit_in(input bit b);
        step(0, 0, 0, 0, 0, 0, 1, b);
    endtask

    task automatic idle();
        step(0, 6'($urandom), 0, 0, 0, 0, 0, 1'($urandom));
    endtask

    initial begin
        bit [12:0] s13;
        bit [5:0]  s6;

        do_reset();

        // Long pattern, target 2.
        cfg(6'b101111, 6, 2);
        go();
        s13 = 13'b1011111101111;
        for (int i = 12; i >= 0; i--) bit_in(s13[i]);
        check("tp1_final_cnt", int'(match_cnt), 2);
        check("tp1_done", int'(done), 1);

        // Non-overlap on 11, target 0.
        cfg(6'b000011, 2, 0);
        go();
        for (int i = 0; i < 4; i++) bit_in(1'b1);
        check("tp2_cnt", int'(match_cnt), 2);
        step(0, 0, 0, 0, 0, 1, 0, 0);

        // Illegal lengths after reset leave nothing loaded.
        do_reset();
        cfg(6'b101010, 0, 1);
        cfg(6'b101010, 7, 1);
        go();
        check("tp3_busy_after_start", int'(busy), 0);

        // Gappy stream.
        cfg(6'b101111, 6, 0);
        go();
        s6 = 6'b101111;
        for (int i = 5; i >= 0; i--) begin
            bit_in(s6[i]);
            step(0, 0, 0, 0, 0, 0, 0, 1'($urandom));
            if (i % 2 == 0) begin
                idle();
                idle();
            end
        end
        check("tp4_cnt", int'(match_cnt), 1);

        // Abort coincident with the completing bit.
        for (int i = 5; i >= 0; i--) bit_in(s6[i]);
        for (int i = 5; i >= 1; i--) bit_in(s6[i]);
        step(0, 0, 0, 0, 0, 1, 1, 1);
        check("tp5_cnt_held", int'(match_cnt), 2);
        check("tp5_idle", int'(busy), 0);
        go();
        check("tp5_cnt_cleared", int'(match_cnt), 0);

        // Reset mid-run.
        for (int i = 5; i >= 3; i--) bit_in(s6[i]);
        do_reset();
        go();
        check("tp6_no_start", int'(busy), 0);

        // Config and start together, then reconfigure from DONE.
        step(1, 6'b000001, 1, 3, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) bit_in(1'b1);
        check("tp7_done", int'(done), 1);
        step(1, 6'b000001, 2, 1, 1, 0, 0, 0);
        bit_in(1'b0);
        bit_in(1'b1);
        check("tp7_done2", int'(done), 1);

        // Counter saturation.
        cfg(6'b000001, 1, 0);
        go();
        for (int i = 0; i < 260; i++) bit_in(1'b1);
        check("sat_cnt", int'(match_cnt), 255);
        step(0, 0, 0, 0, 0, 1, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 7) == 0), 6'($urandom), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 40) == 0), 1'($urandom), 1'($urandom));
        end

        idle();
        idle();
        check("scb_drained", scb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
